// File: rtl/latch_bist.sv
// Built-in self-test sequencer and checker for a gated D latch.
// Steps the latch through a fixed pattern followed by LFSR-generated
// patterns, samples q/nq in the last cycle of every step and compares them
// against a reference latch model. Reports error count, first failing step
// and a pass flag.
//
// state  | meaning
// S_IDLE | waiting for start; result outputs hold the last run's verdict
// S_RUN  | stepping patterns, checking each step at its closing edge
module latch_bist #(
   parameter int         HOLD_CYCLES = 4,
   parameter int         NUM_RAND    = 16,
   parameter logic [7:0] SEED        = 8'hA5,
   localparam int        TOTAL       = 6 + NUM_RAND,
   localparam int        STEP_W      = $clog2(TOTAL)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   output logic              dut_d,
   output logic              dut_e,
   input  logic              dut_q,
   input  logic              dut_nq,
   output logic              busy,
   output logic              done,
   output logic              pass,
   output logic [7:0]        err_count,
   output logic [STEP_W-1:0] fail_step
);

   localparam int                HOLD_W     = (HOLD_CYCLES > 2) ? $clog2(HOLD_CYCLES) : 1;
   localparam logic [HOLD_W-1:0] HOLD_LOAD  = HOLD_W'(HOLD_CYCLES - 1);
   localparam logic [STEP_W-1:0] STEP_LAST  = STEP_W'(TOTAL - 1);
   localparam logic [STEP_W-1:0] STEP_FIXED = STEP_W'(6);

   typedef enum logic {
      S_IDLE = 1'b0,
      S_RUN  = 1'b1
   } state_t;

   state_t              state_q, state_d;
   logic [HOLD_W-1:0]   hold_q, hold_d;
   logic [STEP_W-1:0]   step_q, step_d;
   logic [7:0]          lfsr_q, lfsr_d;
   logic                dut_d_q, dut_d_d;
   logic                dut_e_q, dut_e_d;
   logic                exp_q, exp_d;
   logic                valid_q, valid_d;
   logic                busy_q, busy_d;
   logic                done_q, done_d;
   logic                pass_q, pass_d;
   logic [7:0]          err_q, err_d;
   logic [STEP_W-1:0]   fail_q, fail_d;

   logic [STEP_W-1:0]   step_nxt;
   logic [7:0]          lfsr_adv;
   logic [1:0]          nxt_de;
   logic                chk_fail;
   logic [7:0]          err_sat;

   // Fixed opening sequence, packed as {d, e}; exercises transparent and hold phases.
   function automatic logic [1:0] fixed_de(input logic [2:0] idx);
      logic [1:0] de;
      case (idx)
         3'd1:    de = 2'b01;
         3'd2:    de = 2'b00;
         3'd3:    de = 2'b10;
         3'd4:    de = 2'b11;
         3'd5:    de = 2'b10;
         default: de = 2'b00;
      endcase
      return de;
   endfunction

   assign step_nxt = step_q + STEP_W'(1);
   assign lfsr_adv = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
   assign nxt_de   = (step_nxt < STEP_FIXED) ? fixed_de(step_nxt[2:0])
                                             : {lfsr_adv[0], lfsr_adv[1]};
   // q must match the model and nq must be the complement of q; either failure is one error.
   assign chk_fail = valid_q & ((dut_q ^ exp_q) | ~(dut_nq ^ dut_q));
   assign err_sat  = (err_q == 8'hFF) ? err_q : err_q + 8'd1;

   // State and datapath registers; reset aborts any run without a done pulse.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
         hold_q  <= '0;
         step_q  <= '0;
         lfsr_q  <= SEED;
         dut_d_q <= 1'b0;
         dut_e_q <= 1'b0;
         exp_q   <= 1'b0;
         valid_q <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         pass_q  <= 1'b0;
         err_q   <= 8'd0;
         fail_q  <= '0;
      end else begin
         state_q <= state_d;
         hold_q  <= hold_d;
         step_q  <= step_d;
         lfsr_q  <= lfsr_d;
         dut_d_q <= dut_d_d;
         dut_e_q <= dut_e_d;
         exp_q   <= exp_d;
         valid_q <= valid_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         pass_q  <= pass_d;
         err_q   <= err_d;
         fail_q  <= fail_d;
      end
   end

   // Next-state logic: step timing, check at each step's closing edge, drive next pattern.
   always_comb begin
      state_d = state_q;
      hold_d  = hold_q;
      step_d  = step_q;
      lfsr_d  = lfsr_q;
      dut_d_d = dut_d_q;
      dut_e_d = dut_e_q;
      exp_d   = exp_q;
      valid_d = valid_q;
      busy_d  = busy_q;
      done_d  = 1'b0;
      pass_d  = pass_q;
      err_d   = err_q;
      fail_d  = fail_q;

      case (state_q)
         S_IDLE: begin
            // The done cycle still belongs to the finished run, so start is not taken then.
            if (start && !done_q) begin
               state_d = S_RUN;
               busy_d  = 1'b1;
               err_d   = 8'd0;
               fail_d  = '0;
               pass_d  = 1'b0;
               lfsr_d  = SEED;
               step_d  = '0;
               hold_d  = HOLD_LOAD;
               dut_d_d = 1'b0;
               dut_e_d = 1'b0;
               valid_d = 1'b0;
            end
         end
         S_RUN: begin
            if (hold_q != '0) begin
               hold_d = hold_q - HOLD_W'(1);
            end else begin
               if (chk_fail) begin
                  err_d = err_sat;
                  if (err_q == 8'd0) begin
                     fail_d = step_q;
                  end
               end
               if (step_q == STEP_LAST) begin
                  state_d = S_IDLE;
                  done_d  = 1'b1;
                  busy_d  = 1'b0;
                  pass_d  = (err_d == 8'd0);
                  dut_d_d = 1'b0;
                  dut_e_d = 1'b0;
               end else begin
                  step_d  = step_nxt;
                  hold_d  = HOLD_LOAD;
                  dut_d_d = nxt_de[1];
                  dut_e_d = nxt_de[0];
                  if (step_nxt >= STEP_FIXED) begin
                     lfsr_d = lfsr_adv;
                  end
                  if (nxt_de[0]) begin
                     exp_d   = nxt_de[1];
                     valid_d = 1'b1;
                  end
               end
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   assign dut_d     = dut_d_q;
   assign dut_e     = dut_e_q;
   assign busy      = busy_q;
   assign done      = done_q;
   assign pass      = pass_q;
   assign err_count = err_q;
   assign fail_step = fail_q;

endmodule

// File: tb/tb_latch_bist.sv
// Bench for latch_bist: two instances (16 random steps and none), each driving
// a behavioural latch whose misbehaviour is selected per run. Expected verdicts
// come from a reference model and are queued at start, popped at done.
module tb_latch_bist;

   localparam int H = 4;

   logic clk = 1'b0;
   logic rst;
   logic start;
   logic sel;

   always #5 clk = ~clk;

   logic       start_a, d_a, e_a, q_a, nq_a, busy_a, done_a, pass_a;
   logic [7:0] err_a;
   logic [4:0] fstep_a;
   logic       start_b, d_b, e_b, q_b, nq_b, busy_b, done_b, pass_b;
   logic [7:0] err_b;
   logic [2:0] fstep_b;

   assign start_a = start & ~sel;
   assign start_b = start & sel;

   latch_bist #(.HOLD_CYCLES(H), .NUM_RAND(16), .SEED(8'hA5)) u_dut_a (
      .clk(clk), .rst(rst), .start(start_a), .dut_d(d_a), .dut_e(e_a),
      .dut_q(q_a), .dut_nq(nq_a), .busy(busy_a), .done(done_a), .pass(pass_a),
      .err_count(err_a), .fail_step(fstep_a)
   );

   latch_bist #(.HOLD_CYCLES(H), .NUM_RAND(0), .SEED(8'hA5)) u_dut_b (
      .clk(clk), .rst(rst), .start(start_b), .dut_d(d_b), .dut_e(e_b),
      .dut_q(q_b), .dut_nq(nq_b), .busy(busy_b), .done(done_b), .pass(pass_b),
      .err_count(err_b), .fail_step(fstep_b)
   );

   // Latch under test: 0 ideal, 1 q stuck at 0, 2 nq tied to q, 3 transparent buffer
   int   mode_a = 0;
   int   mode_b = 0;
   logic lat_a = 1'b0;
   logic lat_b = 1'b0;

   always @(d_a or e_a) if (e_a) lat_a = d_a;
   always @(d_b or e_b) if (e_b) lat_b = d_b;

   always @* begin
      case (mode_a)
         1:       begin q_a = 1'b0;  nq_a = 1'b1;  end
         2:       begin q_a = lat_a; nq_a = lat_a; end
         3:       begin q_a = d_a;   nq_a = ~d_a;  end
         default: begin q_a = lat_a; nq_a = ~lat_a; end
      endcase
   end

   always @* begin
      case (mode_b)
         1:       begin q_b = 1'b0;  nq_b = 1'b1;  end
         2:       begin q_b = lat_b; nq_b = lat_b; end
         3:       begin q_b = d_b;   nq_b = ~d_b;  end
         default: begin q_b = lat_b; nq_b = ~lat_b; end
      endcase
   end

   logic       o_done, o_busy, o_pass;
   logic [7:0] o_err, o_fstep;
   assign o_done  = sel ? done_b : done_a;
   assign o_busy  = sel ? busy_b : busy_a;
   assign o_pass  = sel ? pass_b : pass_a;
   assign o_err   = sel ? err_b  : err_a;
   assign o_fstep = sel ? {5'd0, fstep_b} : {3'd0, fstep_a};

   typedef struct {
      int errs;
      int fstep;
      int lat;
   } exp_t;

   exp_t       sb_a[$];
   exp_t       sb_b[$];
   logic [1:0] trace_q[$];
   logic [1:0] seq_de[22];

   int n_checks = 0;
   int n_fail   = 0;

   task automatic build_seq();
      logic [7:0] lf;
      logic       fb;
      seq_de[0] = 2'b00; seq_de[1] = 2'b01; seq_de[2] = 2'b00;
      seq_de[3] = 2'b10; seq_de[4] = 2'b11; seq_de[5] = 2'b10;
      lf = 8'hA5;
      for (int n = 6; n < 22; n++) begin
         fb = ^(lf & 8'hB8);
         lf = {lf[6:0], fb};
         seq_de[n] = {lf[0], lf[1]};
      end
   endtask

   function automatic void model_run(input int mode, input int total,
                                     output int errs, output int fstep);
      logic m_exp, m_valid, lq, q, nq, d, e;
      errs = 0; fstep = 0; m_exp = 1'b0; m_valid = 1'b0; lq = 1'b0;
      for (int n = 0; n < total; n++) begin
         d = seq_de[n][1];
         e = seq_de[n][0];
         if (e) begin m_exp = d; m_valid = 1'b1; lq = d; end
         case (mode)
            1:       begin q = 1'b0; nq = 1'b1; end
            2:       begin q = lq;   nq = lq;   end
            3:       begin q = d;    nq = ~d;   end
            default: begin q = lq;   nq = ~lq;  end
         endcase
         if (m_valid && (q !== m_exp || nq !== ~q)) begin
            if (errs == 0) fstep = n;
            if (errs < 255) errs++;
         end
      end
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push_expected(input int mode);
      exp_t ex;
      int   total;
      total = sel ? 6 : 22;
      model_run(mode, total, ex.errs, ex.fstep);
      ex.lat = total * H;
      if (sel) sb_b.push_back(ex);
      else     sb_a.push_back(ex);
   endtask

   // Starts a run on the selected instance; returns one ns after the accepting edge.
   task automatic launch(input int mode, input bit push);
      if (sel) mode_b = mode;
      else     mode_a = mode;
      if (push) push_expected(mode);
      tick();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic wait_done(output int lat, output bit ok);
      ok = 1'b0;
      lat = 0;
      for (int i = 1; i <= 400 && !ok; i++) begin
         tick();
         if (o_done === 1'b1) begin
            ok = 1'b1;
            lat = i;
         end
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; start = 1'b0; sel = 1'b0;
      #12;
      n_checks++;
      if ({busy_a, done_a, pass_a, d_a, e_a, err_a, fstep_a} !== '0) begin
         n_fail++;
         $display("FAIL reset_a: got busy%b done%b pass%b d%b e%b err%0d fs%0d, want all 0",
                  busy_a, done_a, pass_a, d_a, e_a, err_a, fstep_a);
      end
      n_checks++;
      if ({busy_b, done_b, pass_b, d_b, e_b, err_b, fstep_b} !== '0) begin
         n_fail++;
         $display("FAIL reset_b: got busy%b done%b pass%b d%b e%b err%0d fs%0d, want all 0",
                  busy_b, done_b, pass_b, d_b, e_b, err_b, fstep_b);
      end
      tick();
      rst = 1'b0;
      tick();
      tick();
      n_checks++;
      if (busy_a !== 1'b0 || busy_b !== 1'b0) begin
         n_fail++;
         $display("FAIL idle_after_reset: busy_a=%b busy_b=%b, want 0", busy_a, busy_b);
      end
   endtask

   task automatic test_ideal();
      int   lat;
      bit   ok;
      exp_t ex;
      sel = 1'b0;
      launch(0, 1'b1);
      n_checks++;
      if (o_busy !== 1'b1) begin
         n_fail++;
         $display("FAIL ideal_busy: got %b want 1", o_busy);
      end
      wait_done(lat, ok);
      ex = sb_a.pop_front();
      n_checks++;
      if (!ok || lat != ex.lat) begin
         n_fail++;
         $display("FAIL ideal_latency: got %0d (seen=%0b) want %0d", lat, ok, ex.lat);
      end
      n_checks++;
      if (o_err !== 8'(ex.errs) || o_fstep !== 8'(ex.fstep) || o_pass !== (ex.errs == 0)) begin
         n_fail++;
         $display("FAIL ideal_result: got err%0d fs%0d pass%b want err%0d fs%0d pass%b",
                  o_err, o_fstep, o_pass, ex.errs, ex.fstep, ex.errs == 0);
      end
      n_checks++;
      if (o_busy !== 1'b0 || d_a !== 1'b0 || e_a !== 1'b0) begin
         n_fail++;
         $display("FAIL ideal_end_idle: got busy%b d%b e%b want 0 0 0", o_busy, d_a, e_a);
      end
      tick();
      n_checks++;
      if (o_done !== 1'b0 || o_pass !== 1'b1) begin
         n_fail++;
         $display("FAIL ideal_done_pulse: got done%b pass%b want done0 pass1", o_done, o_pass);
      end
   endtask

   task automatic test_latch_faults();
      int   lat;
      bit   ok;
      exp_t ex;
      sel = 1'b1;
      for (int m = 1; m <= 3; m++) begin
         launch(m, 1'b1);
         wait_done(lat, ok);
         ex = sb_b.pop_front();
         n_checks++;
         if (!ok || lat != ex.lat) begin
            n_fail++;
            $display("FAIL fault%0d_latency: got %0d (seen=%0b) want %0d", m, lat, ok, ex.lat);
         end
         n_checks++;
         if (o_err !== 8'(ex.errs)) begin
            n_fail++;
            $display("FAIL fault%0d_err_count: got %0d want %0d", m, o_err, ex.errs);
         end
         n_checks++;
         if (o_fstep !== 8'(ex.fstep)) begin
            n_fail++;
            $display("FAIL fault%0d_fail_step: got %0d want %0d", m, o_fstep, ex.fstep);
         end
         n_checks++;
         if (o_pass !== (ex.errs == 0)) begin
            n_fail++;
            $display("FAIL fault%0d_pass: got %b want %b", m, o_pass, ex.errs == 0);
         end
      end
   endtask

   task automatic test_busy_start_and_reset();
      int   lat;
      bit   ok;
      int   done_seen;
      exp_t ex;
      sel = 1'b1;
      launch(0, 1'b1);
      ok = 1'b0;
      lat = 0;
      for (int k = 1; k <= 400 && !ok; k++) begin
         start = (k == 6);
         tick();
         if (o_done === 1'b1) begin
            ok = 1'b1;
            lat = k;
         end
      end
      start = 1'b0;
      ex = sb_b.pop_front();
      n_checks++;
      if (!ok || lat != ex.lat) begin
         n_fail++;
         $display("FAIL start_while_busy: done at %0d (seen=%0b) want %0d", lat, ok, ex.lat);
      end

      launch(2, 1'b0);
      for (int k = 1; k <= 10; k++) tick();
      n_checks++;
      if (busy_b !== 1'b1 || err_b !== 8'd1) begin
         n_fail++;
         $display("FAIL midrun_state: got busy%b err%0d want busy1 err1", busy_b, err_b);
      end
      #2;
      rst = 1'b1;
      #1;
      n_checks++;
      if ({busy_b, done_b, pass_b, d_b, e_b, err_b, fstep_b} !== '0) begin
         n_fail++;
         $display("FAIL async_reset: got busy%b done%b pass%b d%b e%b err%0d fs%0d want all 0",
                  busy_b, done_b, pass_b, d_b, e_b, err_b, fstep_b);
      end
      tick();
      tick();
      rst = 1'b0;
      done_seen = 0;
      for (int k = 0; k < 40; k++) begin
         tick();
         if (done_b !== 1'b0 || busy_b !== 1'b0) done_seen++;
      end
      n_checks++;
      if (done_seen != 0) begin
         n_fail++;
         $display("FAIL abort_no_done: got %0d cycles with done/busy, want 0", done_seen);
      end

      launch(0, 1'b1);
      wait_done(lat, ok);
      ex = sb_b.pop_front();
      n_checks++;
      if (!ok || lat != ex.lat || o_err !== 8'(ex.errs) || o_pass !== 1'b1 || o_fstep !== 8'd0) begin
         n_fail++;
         $display("FAIL rerun_after_reset: got lat%0d err%0d fs%0d pass%b want lat%0d err%0d fs0 pass1",
                  lat, o_err, o_fstep, o_pass, ex.lat, ex.errs);
      end
   endtask

   task automatic test_back_to_back();
      int         k;
      bit         ok;
      exp_t       ex;
      logic [1:0] want;
      sel = 1'b0;
      mode_a = 0;
      trace_q.delete();
      push_expected(0);
      tick();
      start = 1'b1;
      tick();
      start = 1'b0;
      ok = 1'b0;
      k = 0;
      while (!ok && k < 400) begin
         if (o_done === 1'b1) begin
            ok = 1'b1;
         end else begin
            want = (k < 22 * H) ? seq_de[k / H] : 2'b00;
            n_checks++;
            if ({d_a, e_a} !== want) begin
               n_fail++;
               $display("FAIL run1_trace cycle %0d: got de=%b want %b", k, {d_a, e_a}, want);
            end
            trace_q.push_back({d_a, e_a});
            tick();
            k++;
         end
      end
      ex = sb_a.pop_front();
      n_checks++;
      if (!ok || k != ex.lat || o_err !== 8'(ex.errs) || o_pass !== 1'b1) begin
         n_fail++;
         $display("FAIL run1_result: got lat%0d err%0d pass%b want lat%0d err%0d pass1",
                  k, o_err, o_pass, ex.lat, ex.errs);
      end

      start = 1'b1;
      tick();
      n_checks++;
      if (busy_a !== 1'b0 || done_a !== 1'b0) begin
         n_fail++;
         $display("FAIL start_in_done_cycle: got busy%b done%b want 0 0", busy_a, done_a);
      end
      push_expected(0);
      tick();
      start = 1'b0;
      n_checks++;
      if (busy_a !== 1'b1) begin
         n_fail++;
         $display("FAIL run2_start: got busy %b want 1", busy_a);
      end
      ok = 1'b0;
      k = 0;
      while (!ok && k < 400) begin
         if (o_done === 1'b1) begin
            ok = 1'b1;
         end else begin
            want = (trace_q.size() > 0) ? trace_q.pop_front() : 2'bxx;
            n_checks++;
            if ({d_a, e_a} !== want) begin
               n_fail++;
               $display("FAIL run2_trace cycle %0d: got de=%b want %b", k, {d_a, e_a}, want);
            end
            tick();
            k++;
         end
      end
      ex = sb_a.pop_front();
      n_checks++;
      if (!ok || k != ex.lat || trace_q.size() != 0 || o_pass !== 1'b1) begin
         n_fail++;
         $display("FAIL run2_result: got lat%0d left%0d pass%b want lat%0d left0 pass1",
                  k, trace_q.size(), o_pass, ex.lat);
      end
   endtask

   initial begin
      build_seq();
      test_reset();
      test_ideal();
      test_latch_faults();
      test_busy_start_and_reset();
      test_back_to_back();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL global_timeout: simulation did not complete, got stall want finish");
      $fatal(1);
   end

endmodule
